// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_add_pkg;

  localparam int SERIAL_ADD_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_full_adder_bit.sv
// 1-bit full adder built from two half adders and an OR of their carries.

module halfadder (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

module full_adder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic s0, c0, c1;

  halfadder u_ha0 (.x_i(a_i), .y_i(b_i), .s_o(s0),  .c_o(c0));
  halfadder u_ha1 (.x_i(s0),  .y_i(c_i), .s_o(s_o), .c_o(c1));

  assign c_o = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: accepts a, b, cin in IDLE, adds LSB first one
// bit per clock through a single full adder in RUN, presents the result in
// DONE until the consumer takes it.
// Optional build macro SERIAL_ADD_OVF_EN adds a signed-overflow output ovf.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;   // operand shift registers, LSB consumed
  logic [WIDTH-1:0] acc_q, acc_d;         // sum bits shifted in from the top
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;         // last completed result
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s, fa_co;

  full_adder_bit u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_co)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

  // Next-state: accept in IDLE, one bit per edge in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        acc_d   = {fa_s, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // After WIDTH shifts bit 0 has reached position 0.
          state_d = DONE;
          sum_d   = {fa_s, acc_q[WIDTH-1:1]};
          cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB here, fa_co the carry out of it.
          ovf_d   = carry_q ^ fa_co;
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: in_valid  input  1  requester presents operands.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: cin  input  1  initial carry-in.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer takes result.
REQ-011 Port: sum  output  WIDTH  result sum.
REQ-012 Port: cout  output  1  final carry-out.

Function
REQ-013 The block SHALL add a+b+cin bit-serially, LSB first, one bit per clock, through a single 1-bit full-adder instance.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 IDLE->RUN on the edge where in_valid&&in_ready: latch a, b and cin into shift/carry registers, clear the bit counter and clear the sum register.
REQ-016 In RUN, each edge SHALL process bit i (i=0..WIDTH-1): shift the full-adder sum into sum[i], update the carry register to the carry-out, and increment the counter.
REQ-017 RUN->DONE on the edge processing bit WIDTH-1; out_valid SHALL rise exactly WIDTH cycles after the accept edge.
REQ-018 In DONE, sum and cout SHALL hold stable until out_valid&&out_ready; on that edge the FSM SHALL go to IDLE.
REQ-019 No new operand SHALL be accepted on the DONE->IDLE edge (no bypass); the minimum accept-to-accept spacing is WIDTH+2 cycles.
REQ-020 in_valid, a, b and cin SHALL be ignored outside IDLE; changes during RUN SHALL not affect the result.
REQ-021 sum SHALL equal (a+b+cin) mod 2^WIDTH, and cout SHALL equal bit WIDTH of the full-width sum.
REQ-022 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL not wrap within an operation.
REQ-023 In IDLE and RUN, sum and cout SHALL hold the last completed result (0 after reset); they update only on the RUN->DONE edge.

Reset
REQ-024 While rst_n=0, the state SHALL be IDLE, in_ready SHALL be 1, out_valid SHALL be 0, and sum, cout, the counter, carry and shift registers SHALL all be 0.
REQ-025 Reset asserted mid-RUN or mid-DONE SHALL abort the operation immediately with no output pulse; the first accept is possible on the first clock edge after deassertion.

Configuration
REQ-026 Macro SERIAL_ADD_OVF_EN, when defined, SHALL add a 1-bit output port ovf: signed two's-complement overflow, equal to the carry into the MSB XOR the carry out of the MSB, captured and held with sum.
REQ-027 Without SERIAL_ADD_OVF_EN, the ovf port and its logic SHALL not exist; all other behaviour is identical.
REQ-028 With SERIAL_ADD_OVF_EN, ovf SHALL reset to 0.

Structure
REQ-029 Shared package serial_add_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default-width constant SERIAL_ADD_WIDTH_DEF=8.
REQ-030 Sub-module full_adder_bit SHALL implement the 1-bit full adder as two halfadder instances plus an OR of their carries; serial_add_ctrl SHALL instantiate it exactly once.

Verification
REQ-031 WIDTH=8: a=0x00, b=0x00, cin=0 -> out_valid 8 cycles after accept, sum=0x00, cout=0.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; ovf=0 when SERIAL_ADD_OVF_EN is defined.
REQ-033 a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0; ovf=1 when SERIAL_ADD_OVF_EN is defined.
REQ-034 Accept a=0x35, b=0x4A, cin=0; hold out_ready=0 for 5 cycles -> sum=0x7F is held, out_valid=1 and in_ready=0 throughout; release -> IDLE on the next edge.
REQ-035 Toggle in_valid, a and b during RUN -> result unchanged; assert rst_n=0 at bit 3 -> out_valid=0, sum=0x00, in_ready=1 with no done pulse.
REQ-036 Random back-to-back operands with random out_ready for 1000 operations -> every result matches the reference model, with accept spacing of at least WIDTH+2 cycles.
